alu_ex_mem_stage: RTL and testbench



---
 rtl/alu_ex_mem_stage_if.sv | 45 ++++
 rtl/alu_ex_mem_stage.sv | 142 ++++++++++++++
 tb/tb_alu_ex_mem_stage.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_ex_mem_stage_if.sv
// EX -> MEM handshake bundle for alu_ex_mem_stage: ALU result/flags in, buffered entry out.
// master = surrounding pipeline (EX producer, MEM consumer), slave = the stage itself.
interface alu_ex_mem_stage_if #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] alu_result;
  logic              alu_nz;
  logic              alu_v;
  logic              alu_co;
  logic              is_branch;
  logic              br_ne;
  logic              chk_ovf;
  logic [RD_W-1:0]   rd_addr;
  logic              reg_write;
  logic [DATA_W-1:0] store_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic              out_zero;
  logic              out_co;
  logic [RD_W-1:0]   out_rd;
  logic              out_reg_write;
  logic [DATA_W-1:0] out_store_data;
  logic              br_taken;
  logic              ovf_trap;
  logic              trap_hold;

  modport master (
    output in_valid, alu_result, alu_nz, alu_v, alu_co, is_branch, br_ne, chk_ovf,
           rd_addr, reg_write, store_data, flush, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_co, out_rd, out_reg_write,
           out_store_data, br_taken, ovf_trap, trap_hold
  );

  modport slave (
    input  in_valid, alu_result, alu_nz, alu_v, alu_co, is_branch, br_ne, chk_ovf,
           rd_addr, reg_write, store_data, flush, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_co, out_rd, out_reg_write,
           out_store_data, br_taken, ovf_trap, trap_hold
  );
endinterface

// File: rtl/alu_ex_mem_stage.sv
// Registered ALU output stage: BEQ/BNE resolution, overflow trap, 2-entry skid buffer to MEM.
// Optional macro ALU_STATUS_CNT_EN adds saturating ovf_cnt/br_cnt event counters.
module alu_ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic                clk,
  input  logic                rst,
  alu_ex_mem_stage_if.slave   bus
`ifdef ALU_STATUS_CNT_EN
  ,
  output logic [15:0]         ovf_cnt,
  output logic [15:0]         br_cnt
`endif
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL, TRAP} state_t;

  typedef struct packed {
    logic signed [DATA_W-1:0] result;
    logic                     zero;
    logic                     co;
    logic [RD_W-1:0]          rd;
    logic                     reg_write;
    logic [DATA_W-1:0]        store_data;
  } ent_t;

  state_t state_q, state_d;
  logic   trap_q, trap_d;
  logic   in_ready_q, in_ready_d;
  logic   br_taken_q, ovf_trap_q;
  logic   vld_p0, vld_p1;
  logic   accept, drain, ovf_in, br_hit;
  logic   ld_p0, ld_p1;
  ent_t   in_ent, d_p0, ent_p0, ent_p1;

  assign vld_p0 = (state_q == ONE) || (state_q == FULL);
  assign vld_p1 = (state_q == FULL);
  assign accept = bus.in_valid & in_ready_q;
  assign drain  = vld_p0 & bus.out_ready;
  // Overflow outranks branch if decode ever asserts both.
  assign ovf_in = bus.chk_ovf & bus.alu_v;
  assign br_hit = bus.is_branch & ~ovf_in & (~bus.alu_nz ^ bus.br_ne);

  always_comb begin
    in_ent            = '0;
    in_ent.result     = bus.alu_result;
    in_ent.zero       = ~bus.alu_nz;
    in_ent.co         = bus.alu_co;
    in_ent.rd         = bus.rd_addr;
    in_ent.reg_write  = bus.reg_write & ~(bus.is_branch | ovf_in);
    in_ent.store_data = bus.store_data;
  end

  always_comb begin
    state_d = state_q;
    trap_d  = trap_q;
    if (bus.flush) begin
      state_d = EMPTY;
      trap_d  = 1'b0;
    end else begin
      unique case (state_q)
        EMPTY:   if (accept) state_d = ONE;
        ONE: begin
          if (accept && !drain)      state_d = FULL;
          else if (drain && !accept) state_d = EMPTY;
        end
        FULL:    if (drain) state_d = ONE;
        TRAP:    state_d = TRAP;
        default: state_d = EMPTY;
      endcase
      if (accept && ovf_in) trap_d = 1'b1;
      // A pending trap lets older entries drain, then parks in TRAP.
      if (trap_d && (state_d == EMPTY)) state_d = TRAP;
    end
    in_ready_d = ((state_d == EMPTY) || (state_d == ONE)) && !trap_d;
  end

  always_comb begin
    ld_p0 = 1'b0;
    ld_p1 = 1'b0;
    d_p0  = in_ent;
    if (drain && vld_p1) begin
      ld_p0 = 1'b1;
      d_p0  = ent_p1;
    end else if (accept && (!vld_p0 || drain)) begin
      ld_p0 = 1'b1;
    end
    ld_p1 = accept & vld_p0 & ~drain;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      trap_q     <= 1'b0;
      in_ready_q <= 1'b1;
      br_taken_q <= 1'b0;
      ovf_trap_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      trap_q     <= trap_d;
      in_ready_q <= in_ready_d;
      br_taken_q <= accept & ~bus.flush & br_hit;
      ovf_trap_q <= accept & ~bus.flush & ovf_in;
    end
  end

  // ---- skid slots: p0 is the head presented to MEM, p1 the overflow slot ----
  always_ff @(posedge clk) begin
    if (ld_p0) ent_p0 <= d_p0;
    if (ld_p1) ent_p1 <= in_ent;
  end

  assign bus.in_ready       = in_ready_q;
  assign bus.out_valid      = vld_p0;
  assign bus.out_result     = vld_p0 ? ent_p0.result     : '0;
  assign bus.out_zero       = vld_p0 & ent_p0.zero;
  assign bus.out_co         = vld_p0 & ent_p0.co;
  assign bus.out_rd         = vld_p0 ? ent_p0.rd         : '0;
  assign bus.out_reg_write  = vld_p0 & ent_p0.reg_write;
  assign bus.out_store_data = vld_p0 ? ent_p0.store_data : '0;
  assign bus.br_taken       = br_taken_q;
  assign bus.ovf_trap       = ovf_trap_q;
  assign bus.trap_hold      = trap_q;

`ifdef ALU_STATUS_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_cnt <= '0;
      br_cnt  <= '0;
    end else begin
      if (ovf_trap_q) ovf_cnt <= sat_inc(ovf_cnt);
      if (br_taken_q) br_cnt  <= sat_inc(br_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_alu_ex_mem_stage.sv
// Directed scoreboard bench for alu_ex_mem_stage; checks counters when ALU_STATUS_CNT_EN is defined.
module tb_alu_ex_mem_stage;
  localparam int DATA_W = 32;
  localparam int RD_W   = 5;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic        co;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] sd;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_ex_mem_stage_if #(.DATA_W(DATA_W), .RD_W(RD_W)) bus ();

`ifdef ALU_STATUS_CNT_EN
  logic [15:0] ovf_cnt, br_cnt;
`endif

  alu_ex_mem_stage #(.DATA_W(DATA_W), .RD_W(RD_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ALU_STATUS_CNT_EN
    ,
    .ovf_cnt (ovf_cnt),
    .br_cnt  (br_cnt)
`endif
  );

  int          total = 0;
  int          bad   = 0;
  ent_t        q[$];
  logic        trap_m  = 1'b0;
  logic        pend_br = 1'b0;
  logic        pend_ovf = 1'b0;
  logic [15:0] cnt_br  = 16'd0;
  logic [15:0] cnt_ovf = 16'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [31:0] res, input logic nz, input logic v, input logic co,
                     input logic br, input logic ne, input logic ck, input logic [4:0] rd,
                     input logic rw, input logic [31:0] sd);
    bus.in_valid   = 1'b1;
    bus.alu_result = res;
    bus.alu_nz     = nz;
    bus.alu_v      = v;
    bus.alu_co     = co;
    bus.is_branch  = br;
    bus.br_ne      = ne;
    bus.chk_ovf    = ck;
    bus.rd_addr    = rd;
    bus.reg_write  = rw;
    bus.store_data = sd;
  endtask

  task automatic idle();
    bus.in_valid  = 1'b0;
    bus.is_branch = 1'b0;
    bus.chk_ovf   = 1'b0;
    bus.alu_v     = 1'b0;
  endtask

  // One clock: score handshakes before the edge, check control outputs after it.
  task automatic cycle();
    ent_t e;
    logic acc, drn, ovf;
    #1;
    acc = bus.in_valid & bus.in_ready;
    drn = bus.out_valid & bus.out_ready;
    if (rst) begin
      cnt_br  = 16'd0;
      cnt_ovf = 16'd0;
    end else begin
      if (pend_br  && cnt_br  != 16'hFFFF) cnt_br++;
      if (pend_ovf && cnt_ovf != 16'hFFFF) cnt_ovf++;
    end
    if (drn && q.size() != 0) begin
      e = q.pop_front();
      chk("out_result",     bus.out_result,             e.res);
      chk("out_zero",       32'(bus.out_zero),          32'(e.zero));
      chk("out_co",         32'(bus.out_co),            32'(e.co));
      chk("out_rd",         32'(bus.out_rd),            32'(e.rd));
      chk("out_reg_write",  32'(bus.out_reg_write),     32'(e.rw));
      chk("out_store_data", bus.out_store_data,         e.sd);
    end
    pend_br  = 1'b0;
    pend_ovf = 1'b0;
    if (rst || bus.flush) begin
      q.delete();
      trap_m = 1'b0;
    end else if (acc) begin
      ovf    = bus.chk_ovf & bus.alu_v;
      e.res  = bus.alu_result;
      e.zero = ~bus.alu_nz;
      e.co   = bus.alu_co;
      e.rd   = bus.rd_addr;
      e.rw   = bus.reg_write & ~(bus.is_branch | ovf);
      e.sd   = bus.store_data;
      q.push_back(e);
      pend_ovf = ovf;
      pend_br  = bus.is_branch & ~ovf & (~bus.alu_nz ^ bus.br_ne);
      if (ovf) trap_m = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
    chk("in_ready",  32'(bus.in_ready),  32'(!trap_m && (q.size() < 2)));
    chk("trap_hold", 32'(bus.trap_hold), 32'(trap_m));
    chk("br_taken",  32'(bus.br_taken),  32'(pend_br));
    chk("ovf_trap",  32'(bus.ovf_trap),  32'(pend_ovf));
  endtask

  initial begin
    bus.flush      = 1'b0;
    bus.out_ready  = 1'b0;
    bus.alu_result = '0;
    bus.alu_nz     = 1'b0;
    bus.alu_co     = 1'b0;
    bus.br_ne      = 1'b0;
    bus.rd_addr    = '0;
    bus.reg_write  = 1'b0;
    bus.store_data = '0;
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // reset state
    chk("rst_out_valid",      32'(bus.out_valid),     32'd0);
    chk("rst_out_result",     bus.out_result,         32'd0);
    chk("rst_out_zero",       32'(bus.out_zero),      32'd0);
    chk("rst_out_reg_write",  32'(bus.out_reg_write), 32'd0);
    chk("rst_out_store_data", bus.out_store_data,     32'd0);
    chk("rst_br_taken",       32'(bus.br_taken),      32'd0);
    chk("rst_ovf_trap",       32'(bus.ovf_trap),      32'd0);
    chk("rst_trap_hold",      32'(bus.trap_hold),     32'd0);
    chk("rst_in_ready",       32'(bus.in_ready),      32'd1);

    // back-to-back streaming with MEM always ready
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      put(32'(i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'(i), 1'b1, 32'h100 + 32'(i));
      cycle();
    end
    idle();
    repeat (2) cycle();

    // MEM stalled: two entries fill the buffer, third waits
    bus.out_ready = 1'b0;
    put(32'hA, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd10, 1'b1, 32'hAAAA); cycle();
    put(32'hB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd11, 1'b1, 32'hBBBB); cycle();
    put(32'hC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd12, 1'b1, 32'hCCCC); cycle();
    bus.out_ready = 1'b1;
    cycle();
    cycle();
    idle();
    repeat (2) cycle();

    // branch resolution
    put(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 1'b1, 32'h0); cycle();
    put(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd4, 1'b1, 32'h0); cycle();
    put(32'h5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 1'b1, 32'h0); cycle();
    put(32'h5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd6, 1'b1, 32'h0); cycle();
    idle();
    repeat (2) cycle();

    // overflow behind an older entry, then frozen until flush
    bus.out_ready = 1'b0;
    put(32'h7,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b1, 32'h7); cycle();
    put(32'h80000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b1, 32'h8); cycle();
    put(32'h55,       1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd9, 1'b1, 32'h9); cycle();
    bus.out_ready = 1'b1;
    repeat (3) cycle();
    idle();
    bus.flush = 1'b1; cycle();
    bus.flush = 1'b0; cycle();

    // overflow and branch together from empty: overflow wins
    put(32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 1'b1, 32'h0); cycle();
    idle();
    repeat (2) cycle();
    bus.flush = 1'b1; cycle();
    bus.flush = 1'b0; cycle();

    // flush beats a same-cycle accept
    bus.out_ready = 1'b0;
    put(32'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 32'h11); cycle();
    put(32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd2, 1'b1, 32'h0);
    bus.flush = 1'b1; cycle();
    put(32'h80000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 1'b1, 32'h0); cycle();
    bus.flush = 1'b0;
    idle();
    cycle();

    // reset in the middle of traffic, including a pending branch pulse
    put(32'h21, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd21, 1'b1, 32'h21); cycle();
    put(32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd22, 1'b1, 32'h22); cycle();
    idle();
    rst = 1'b1; cycle();
    rst = 1'b0; cycle();

    // 3 taken branches and 2 traps
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      put(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 1'b0, 32'h0);
      cycle();
    end
    for (int i = 0; i < 2; i++) begin
      put(32'h80000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 1'b1, 32'h0);
      cycle();
      idle();
      cycle();
      bus.flush = 1'b1; cycle();
      bus.flush = 1'b0; cycle();
    end
    idle();
    repeat (2) cycle();

`ifdef ALU_STATUS_CNT_EN
    chk("br_cnt",  32'(br_cnt),  32'(cnt_br));
    chk("ovf_cnt", 32'(ovf_cnt), 32'(cnt_ovf));
    chk("br_cnt_3",  32'(br_cnt),  32'd3);
    chk("ovf_cnt_2", 32'(ovf_cnt), 32'd2);
    put(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 1'b0, 32'h0);
    bus.out_ready = 1'b1;
    repeat (65540) @(negedge clk);
    idle();
    repeat (3) @(negedge clk);
    chk("br_cnt_sat", 32'(br_cnt), 32'hFFFF);
    put(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 1'b0, 32'h0);
    repeat (4) @(negedge clk);
    idle();
    repeat (3) @(negedge clk);
    chk("br_cnt_sat_hold", 32'(br_cnt), 32'hFFFF);
    chk("ovf_cnt_kept",    32'(ovf_cnt), 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
